wordcopy_sched: RTL



---
 rtl/wordcopy_sched.sv | 342 ++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/wordcopy_sched.sv
// Purpose : descriptor-queue scheduler that feeds copy jobs from the CPU to the word-copy accelerator.
// Latency : push at edge N -> pop at N+1 -> first accelerator write presented from N+2; 5 bus cycles per job plus accelerator busy time.
// Backpres: CPU port never stalls (pushes into a full queue are dropped and flagged); accelerator waitrequest holds the current master access.
//
// Ports
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   slave_*                  CPU-facing Avalon-MM slave (addr 0 push/status, 1 dst, 2 src, 3 cnt, 4 done_count, 5 irq_en, 6 irq clear)
//   master_*                 accelerator-facing Avalon-MM master (register writes and completion poll)
//   irq                      completion interrupt, present only when WCSCHED_IRQ_EN is defined
//
// Build option: define WCSCHED_IRQ_EN to add the drain interrupt (irq port, irq_en at addr 5, clear at addr 6).

module wordcopy_sched #(
    parameter int DEPTH = 4                     // descriptor queue depth, power of two, 2..16
) (
    input  logic        clk,
    input  logic        rst,
    // CPU slave port
    output logic        slave_waitrequest,
    input  logic [3:0]  slave_address,
    input  logic        slave_read,
    output logic [31:0] slave_readdata,
    input  logic        slave_write,
    input  logic [31:0] slave_writedata,
    // accelerator master port
    input  logic        master_waitrequest,
    output logic [3:0]  master_address,
    output logic        master_read,
    input  logic [31:0] master_readdata,
    output logic        master_write,
    output logic [31:0] master_writedata
`ifdef WCSCHED_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int OCW = $clog2(DEPTH) + 1;     // occupancy counter width (0..DEPTH)

    // FSM encoding
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SET_DST = 3'd1;
    localparam logic [2:0] S_SET_SRC = 3'd2;
    localparam logic [2:0] S_SET_CNT = 3'd3;
    localparam logic [2:0] S_START   = 3'd4;
    localparam logic [2:0] S_POLL    = 3'd5;

    typedef struct packed {
        logic [31:0] dst;
        logic [31:0] src;
        logic [31:0] cnt;
    } desc_t;

    // ------------------------------------------------------------------
    // Registers and wires
    // ------------------------------------------------------------------
    logic [2:0]     r_state;
    desc_t          r_stg;                      // staged descriptor fields
    desc_t          r_cur;                      // job currently being driven
    logic [31:0]    r_done_cnt;
    logic           r_ovf;

    desc_t          w_head;
    logic           w_empty;
    logic           w_full;
    logic [OCW-1:0] w_occ;
    logic           w_push_req;
    logic           w_push_acc;
    logic           w_pop;
    logic           w_job_done;
    logic           w_stat_rd;
    logic [31:0]    w_status;
    logic [31:0]    w_rdata;
    logic           w_unused;

    // The accelerator's read data carries nothing we need: completion is
    // signalled purely by the release of waitrequest on the poll read.
    assign w_unused = ^master_readdata;

    assign slave_waitrequest = 1'b0;

    assign w_push_req = slave_write && (slave_address == 4'd0);
    assign w_push_acc = w_push_req && !w_full;
    assign w_pop      = (r_state == S_IDLE) && !w_empty;
    assign w_stat_rd  = slave_read && (slave_address == 4'd0);

    // A job finishes either when a zero-length descriptor is retired in
    // IDLE without touching the accelerator, or when the poll read is
    // finally accepted.
    assign w_job_done = (w_pop && (w_head.cnt == 32'd0)) ||
                        ((r_state == S_POLL) && !master_waitrequest);

    // ------------------------------------------------------------------
    // Descriptor queue
    // ------------------------------------------------------------------
    wcs_fifo #(
        .WIDTH ($bits(desc_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push_vld (w_push_req),
        .i_push_dat (r_stg),
        .i_pop_rdy  (w_pop),
        .o_pop_dat  (w_head),
        .o_empty    (w_empty),
        .o_full     (w_full),
        .o_count    (w_occ)
    );

    // ------------------------------------------------------------------
    // CPU-side staging registers and sticky overflow
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stg <= '0;
            r_ovf <= 1'b0;
        end else begin
            if (slave_write) begin
                case (slave_address)
                    4'd1:    r_stg.dst <= slave_writedata;
                    4'd2:    r_stg.src <= slave_writedata;
                    4'd3:    r_stg.cnt <= slave_writedata;
                    default: ;
                endcase
            end
            // A drop in the same cycle as a status read keeps the flag so
            // the newly lost push is still reported on the next read.
            if (w_push_req && w_full) begin
                r_ovf <= 1'b1;
            end else if (w_stat_rd) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Job sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cur      <= '0;
            r_done_cnt <= 32'd0;
        end else begin
            if (w_job_done) begin
                r_done_cnt <= r_done_cnt + 32'd1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_cur <= w_head;
                        // zero-length jobs are retired here and never reach the accelerator
                        if (w_head.cnt != 32'd0) begin
                            r_state <= S_SET_DST;
                        end
                    end
                end
                S_SET_DST: if (!master_waitrequest) r_state <= S_SET_SRC;
                S_SET_SRC: if (!master_waitrequest) r_state <= S_SET_CNT;
                S_SET_CNT: if (!master_waitrequest) r_state <= S_START;
                S_START:   if (!master_waitrequest) r_state <= S_POLL;
                S_POLL:    if (!master_waitrequest) r_state <= S_IDLE;
                default:   r_state <= S_IDLE;
            endcase
        end
    end

    // Master outputs decode straight from registered state so they hold
    // steady for as long as the accelerator asserts waitrequest.
    always_comb begin
        master_address   = 4'd0;
        master_read      = 1'b0;
        master_write     = 1'b0;
        master_writedata = 32'd0;
        case (r_state)
            S_SET_DST: begin
                master_write     = 1'b1;
                master_address   = 4'd1;
                master_writedata = r_cur.dst;
            end
            S_SET_SRC: begin
                master_write     = 1'b1;
                master_address   = 4'd2;
                master_writedata = r_cur.src;
            end
            S_SET_CNT: begin
                master_write     = 1'b1;
                master_address   = 4'd3;
                master_writedata = r_cur.cnt;
            end
            S_START: begin
                master_write     = 1'b1;
                master_address   = 4'd0;
            end
            S_POLL: begin
                master_read      = 1'b1;
                master_address   = 4'd0;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Optional drain interrupt
    // ------------------------------------------------------------------
`ifdef WCSCHED_IRQ_EN
    logic           r_irq_en;
    logic           r_irq_pend;
    logic [OCW-1:0] w_occ_next;
    logic           w_drain;

    // Queue occupancy after this edge; the interrupt marks the queue
    // running dry, so a push landing with the completion suppresses it.
    always_comb begin
        w_occ_next = w_occ;
        if (w_push_acc && !w_pop) begin
            w_occ_next = w_occ + OCW'(1);
        end else if (!w_push_acc && w_pop) begin
            w_occ_next = w_occ - OCW'(1);
        end
    end

    assign w_drain = w_job_done && (w_occ_next == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_irq_en   <= 1'b0;
            r_irq_pend <= 1'b0;
        end else begin
            if (slave_write && (slave_address == 4'd5)) begin
                r_irq_en <= slave_writedata[0];
            end
            // set wins over a coincident clear so no drain event is lost
            if (w_drain) begin
                r_irq_pend <= 1'b1;
            end else if (slave_write && (slave_address == 4'd6)) begin
                r_irq_pend <= 1'b0;
            end
        end
    end

    assign irq = r_irq_pend && r_irq_en;
`else
    // Without the interrupt option the push-accept qualifier has no user.
    logic w_unused_push;
    assign w_unused_push = w_push_acc;
`endif

    // ------------------------------------------------------------------
    // CPU read path (combinational, same cycle as slave_read)
    // ------------------------------------------------------------------
    always_comb begin
        w_status       = 32'd0;
        w_status[0]    = (r_state != S_IDLE);
        w_status[1]    = w_empty;
        w_status[2]    = w_full;
        w_status[3]    = r_ovf;
        w_status[12:8] = 5'(w_occ);
    end

    always_comb begin
        w_rdata = 32'd0;
        case (slave_address)
            4'd0:    w_rdata = w_status;
            4'd4:    w_rdata = r_done_cnt;
`ifdef WCSCHED_IRQ_EN
            4'd5:    w_rdata = {31'd0, r_irq_en};
`endif
            default: w_rdata = 32'd0;
        endcase
    end

    assign slave_readdata = slave_read ? w_rdata : 32'd0;

endmodule

// Purpose : generic register-array FIFO used for the descriptor queue.
// Latency : a push at edge N is visible at the head (and poppable) from N+1.
// Backpres: push while full is ignored; pop while empty is ignored.
module wcs_fifo #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push_vld,
    input  logic [WIDTH-1:0]         i_push_dat,
    input  logic                     i_pop_rdy,
    output logic [WIDTH-1:0]         o_pop_dat,
    output logic                     o_empty,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(DEPTH));
    assign o_count   = r_count;
    assign o_pop_dat = r_mem[r_rd_ptr];

    assign w_push = i_push_vld && !o_full;
    assign w_pop  = i_pop_rdy && !o_empty;

    // storage carries no reset; only the pointers define validity
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

endmodule
